// File: rtl/dmem_pkg.sv
// Shared funct3 encodings, FSM state type and size-mask helper for dmem_sized.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } dmem_state_t;

  // Byte mask for the access size encoded in funct3[1:0].
  function automatic logic [7:0] size_mask(input logic [2:0] funct3);
    logic [7:0] m;
    case (funct3[1:0])
      2'b00:   m = 8'h01;
      2'b01:   m = 8'h03;
      2'b10:   m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane alignment: store byte enables/data shift, load extract and
// extend, plus misalignment and illegal-funct3 detection.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [2:0]  req_lane,
  input  logic [63:0] req_wdata,
  output logic [7:0]  st_be_c,
  output logic [63:0] st_data_c,
  output logic        misalign_c,
  output logic        illegal_c,
  input  logic [2:0]  ld_funct3,
  input  logic [2:0]  ld_lane,
  input  logic [63:0] ld_word,
  output logic [63:0] ld_data_c
);

  logic [63:0] ld_shift;

  always_comb begin
    st_be_c   = size_mask(req_funct3) << req_lane;
    st_data_c = req_wdata << {req_lane, 3'b000};
    illegal_c = req_we ? req_funct3[2] : (req_funct3 == 3'b111);
    case (req_funct3[1:0])
      2'b01:   misalign_c = req_lane[0];
      2'b10:   misalign_c = |req_lane[1:0];
      2'b11:   misalign_c = |req_lane;
      default: misalign_c = 1'b0;
    endcase
  end

  always_comb begin
    ld_shift = ld_word >> {ld_lane, 3'b000};
    case (ld_funct3)
      F3_B:    ld_data_c = {{56{ld_shift[7]}},  ld_shift[7:0]};
      F3_H:    ld_data_c = {{48{ld_shift[15]}}, ld_shift[15:0]};
      F3_W:    ld_data_c = {{32{ld_shift[31]}}, ld_shift[31:0]};
      F3_D:    ld_data_c = ld_shift;
      F3_BU:   ld_data_c = {56'd0, ld_shift[7:0]};
      F3_HU:   ld_data_c = {48'd0, ld_shift[15:0]};
      F3_WU:   ld_data_c = {32'd0, ld_shift[31:0]};
      default: ld_data_c = '0;
    endcase
  end

endmodule

// File: rtl/dmem_sized.sv
// Sized RV64I data memory with fault reporting and a post-reset zeroing sweep.
// Define DMEM_DEBUG_PORT_EN to add the dbg_addr/dbg_rdata read port.
module dmem_sized
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_fault,
  output logic        init_done
`ifdef DMEM_DEBUG_PORT_EN
  ,
  input  logic [$clog2(DEPTH)-1:0] dbg_addr,
  output logic [63:0]              dbg_rdata
`endif
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [63:0] mem [DEPTH];

  dmem_state_t      state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             req_ready_q, req_ready_d;
  logic             p1_valid_q, p1_valid_d;
  logic             p1_we_q, p1_we_d;
  logic             p1_fault_q, p1_fault_d;
  logic [2:0]       p1_lane_q, p1_lane_d;
  logic [2:0]       p1_funct3_q, p1_funct3_d;
  logic [63:0]      p1_word_q, p1_word_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_fault_q, resp_fault_d;
  logic [63:0]      resp_rdata_q, resp_rdata_d;

  logic             accept_c, oor_c, fault_c, store_en_c;
  logic             misalign_c, illegal_c;
  logic [IDX_W-1:0] idx_c;
  logic [2:0]       lane_c;
  logic [7:0]       st_be_c;
  logic [63:0]      st_data_c, ld_data_c;

  assign idx_c  = req_addr[IDX_W+2:3];
  assign lane_c = req_addr[2:0];
  assign oor_c  = req_addr[63:3] >= 61'(DEPTH);

  dmem_lane_align u_align (
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_lane   (lane_c),
    .req_wdata  (req_wdata),
    .st_be_c    (st_be_c),
    .st_data_c  (st_data_c),
    .misalign_c (misalign_c),
    .illegal_c  (illegal_c),
    .ld_funct3  (p1_funct3_q),
    .ld_lane    (p1_lane_q),
    .ld_word    (p1_word_q),
    .ld_data_c  (ld_data_c)
  );

  // Sweep sequencing, request capture (stage 1) and response formation (stage 2).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == INIT) begin
      cnt_d = cnt_q + IDX_W'(1);
      if (cnt_q == IDX_W'(DEPTH - 1)) begin
        state_d = RUN;
        cnt_d   = '0;
      end
    end
    req_ready_d = (state_d == RUN);

    accept_c   = req_valid & req_ready_q;
    fault_c    = oor_c | misalign_c | illegal_c;
    store_en_c = accept_c & req_we & ~fault_c;

    p1_valid_d  = accept_c;
    p1_we_d     = req_we;
    p1_fault_d  = fault_c;
    p1_lane_d   = lane_c;
    p1_funct3_d = req_funct3;
    p1_word_d   = oor_c ? 64'd0 : mem[idx_c];

    resp_valid_d = p1_valid_q;
    resp_fault_d = p1_valid_q & p1_fault_q;
    resp_rdata_d = (p1_valid_q & ~p1_we_q & ~p1_fault_q) ? ld_data_c : 64'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= INIT;
      cnt_q        <= '0;
      req_ready_q  <= 1'b0;
      p1_valid_q   <= 1'b0;
      p1_we_q      <= 1'b0;
      p1_fault_q   <= 1'b0;
      p1_lane_q    <= '0;
      p1_funct3_q  <= '0;
      p1_word_q    <= '0;
      resp_valid_q <= 1'b0;
      resp_fault_q <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      p1_valid_q   <= p1_valid_d;
      p1_we_q      <= p1_we_d;
      p1_fault_q   <= p1_fault_d;
      p1_lane_q    <= p1_lane_d;
      p1_funct3_q  <= p1_funct3_d;
      p1_word_q    <= p1_word_d;
      resp_valid_q <= resp_valid_d;
      resp_fault_q <= resp_fault_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // Array write port: sweep zeroing in INIT, byte-masked stores in RUN.
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      mem[cnt_q] <= '0;
    end else if (store_en_c) begin
      for (int b = 0; b < 8; b++) begin
        if (st_be_c[b]) mem[idx_c][8*b +: 8] <= st_data_c[8*b +: 8];
      end
    end
  end

  assign req_ready  = req_ready_q;
  assign init_done  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_fault = resp_fault_q;
  assign resp_rdata = resp_rdata_q;

`ifdef DMEM_DEBUG_PORT_EN
  logic [63:0] dbg_rdata_q, dbg_rdata_d, dbg_word_c;

  if (DEPTH == (1 << IDX_W)) begin : g_dbg_full
    assign dbg_word_c = mem[dbg_addr];
  end else begin : g_dbg_part
    assign dbg_word_c = (32'(dbg_addr) < DEPTH) ? mem[dbg_addr] : 64'd0;
  end

  // Reads the array before this edge's store lands, so a same-edge hit sees old data.
  always_comb begin
    dbg_rdata_d = (state_q == RUN) ? dbg_word_c : dbg_rdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) dbg_rdata_q <= '0;
    else     dbg_rdata_q <= dbg_rdata_d;
  end

  assign dbg_rdata = dbg_rdata_q;
`endif

endmodule
